// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the single-clock simple dual-port RAM.
// Build option: SYNC_RAM_BYPASS_EN selects write-first read-during-write.
package sync_ram_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } sync_ram_state_t;

    // Address width for a given depth, never less than 1 bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Reset-less storage with one write port, one combinational read port and the
// read-data register (the only reset state here).
module sync_ram_array #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 256,
    parameter int unsigned AddrW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rd_word_o,
    input  logic             rd_load_i,
    input  logic [Width-1:0] rd_next_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Sampled before this edge's write lands, so the raw port is read-first.
    assign rd_word_o = mem_q[raddr_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rd_load_i) begin
            rdata_q <= rd_next_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_dual_port_ram.sv
// Single-clock simple dual-port RAM with post-reset clear sequence and READY.
// Define SYNC_RAM_BYPASS_EN for write-first; otherwise read-first.
module sync_dual_port_ram
    import sync_ram_pkg::*;
#(
    parameter int unsigned          WIDTH      = 8,
    parameter int unsigned          DEPTH      = 256,
    parameter logic [WIDTH-1:0]     INIT_VALUE = '0,
    localparam int unsigned         ADDR_W     = addr_width(DEPTH)
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RADDR,
    output logic [WIDTH-1:0]  RDATA,
    output logic              RVALID,
    output logic              READY
);

    localparam logic [ADDR_W:0]   DepthC   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    sync_ram_state_t   state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;
    logic              rvalid_q;

    logic              waddr_ok;
    logic              raddr_ok;
    logic              user_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WIDTH-1:0]  arr_wdata;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  rd_next;
    logic              rd_load;

    assign waddr_ok = ({1'b0, WADDR} < DepthC);
    assign raddr_ok = ({1'b0, RADDR} < DepthC);
    assign user_we  = (state_q == RUN) && WE && waddr_ok;
    assign rd_load  = (state_q == RUN) && RE;

    always_comb begin
        arr_we    = user_we;
        arr_waddr = WADDR;
        arr_wdata = WDATA;
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
            arr_wdata = INIT_VALUE;
        end
    end

    always_comb begin
        rd_next = rd_word;
        if (!raddr_ok) begin
            rd_next = INIT_VALUE;
        end
`ifdef SYNC_RAM_BYPASS_EN
        else if (user_we && (WADDR == RADDR)) begin
            rd_next = WDATA;
        end
`endif
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    rvalid_q <= 1'b0;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    rvalid_q <= RE;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    sync_ram_array #(
        .Width(WIDTH),
        .Depth(DEPTH),
        .AddrW(ADDR_W)
    ) u_array (
        .clk_i    (CLK),
        .rst_ni   (ASYNCRESETN),
        .we_i     (arr_we),
        .waddr_i  (arr_waddr),
        .wdata_i  (arr_wdata),
        .raddr_i  (RADDR),
        .rd_word_o(rd_word),
        .rd_load_i(rd_load),
        .rd_next_i(rd_next),
        .rdata_o  (RDATA)
    );

    assign RVALID = rvalid_q;
    assign READY  = ready_q;

endmodule

// File: doc/sync_dual_port_ram.md
# sync_dual_port_ram

Parametrised single-clock, simple dual-port RAM: one write port and one read port with a registered read, for designs that drive both RAM ports from the same `CLK`. It adds an automatic post-reset clear sequence with a `READY` flag, a read-valid strobe, and selectable read-during-write behaviour. It is instantiated directly inside datapath blocks as their local buffer.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 256, number of words (≥2; need not be a power of two)
- `INIT_VALUE`, 0, `WIDTH`-bit value written to every word by the clear sequence
- `ADDR_W`, derived localparam = clog2(`DEPTH`), address width

Ports:
- `CLK`  in  1  sole clock; all state updates on its rising edge
- `ASYNCRESETN`  in  1  asynchronous, active-low reset
- `WE`  in  1  write enable
- `WADDR`  in  `ADDR_W`  write address
- `WDATA`  in  `WIDTH`  write data
- `RE`  in  1  read enable
- `RADDR`  in  `ADDR_W`  read address
- `RDATA`  out  `WIDTH`  registered read data
- `RVALID`  out  1  one-cycle strobe: `RDATA` updated by a read
- `READY`  out  1  clear sequence done; ports accepted

## Operation
- FSM states `CLEAR` and `RUN`. Reset forces `CLEAR`, clear counter = 0, `READY`=0, `RVALID`=0, `RDATA`=0.
- `CLEAR`: each edge writes `INIT_VALUE` to mem[counter] and increments the counter. On the edge that writes `DEPTH-1`, the FSM moves to `RUN` and `READY` goes to 1.
- During `CLEAR`, `WE` and `RE` are ignored. No user write reaches memory, and `RVALID` stays 0.
- `RUN` write: `WE`=1 and `WADDR` < `DEPTH` writes `WDATA` to mem[`WADDR`]. An out-of-range `WADDR` drops the write silently.
- `RUN` read: `RE`=1 registers mem[`RADDR`] into `RDATA` and sets `RVALID`=1 for exactly one cycle. An out-of-range `RADDR` returns `INIT_VALUE` and still sets `RVALID`.
- `RE`=0: `RDATA` holds its last value and `RVALID`=0.
- Simultaneous read and write to the same address: behaviour is set by the configuration macro. Reads and writes to different addresses are fully independent.
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronously). After release the clear sequence reruns and overwrites all contents.
- The memory array itself has no reset. Only the clear sequence initialises it.

## Timing
- Clear duration is `DEPTH` edges after `ASYNCRESETN` deasserts. `READY` is 1 after edge `DEPTH` (edges counted from 1).
- Read latency is 1. `RE` sampled at edge N gives `RDATA`/`RVALID` valid after edge N, until edge N+1.
- A write at edge N is visible to a read sampled at edge N+1 or later.
- Back-to-back reads every cycle are supported. `RVALID` stays high continuously.

## Configuration
- `SYNC_RAM_BYPASS_EN` defined: write-first. A same-cycle read of the written address returns `WDATA`.
- Not defined: read-first. The same read returns the old memory contents, and the new data is visible from the next read.

## Structure
- Package `sync_ram_pkg` holds:
  - the state typedef `sync_ram_state_t` {`CLEAR`, `RUN`}
  - the clog2-based address-width function used to derive `ADDR_W`
- Sub-module `sync_ram_array` holds:
  - the reset-less storage array, one write port and one read port
  - the read-data register
- The top level holds the FSM, clear counter, range checks, bypass mux, and `RVALID`/`READY` logic.

## Test plan
Run with `WIDTH`=8, `DEPTH`=12, `INIT_VALUE`=0x00.
- Release reset → `READY`=0 for 12 edges, then 1 after edge 12. `RDATA`=0x00 and `RVALID`=0 throughout.
- After `READY`, read addresses 0..11 back-to-back → every `RDATA`=0x00, `RVALID` high for 12 consecutive cycles.
- Write 0xA5 to address 3; `RE` on addr 3 the next cycle → `RDATA`=0xA5 with a single `RVALID` pulse. After `RE` drops, `RDATA` holds 0xA5.
- Preload addr 7 with 0x11. Same edge: write 0x5A to 7 and read 7 → 0x5A with `SYNC_RAM_BYPASS_EN`, else 0x11. The next read of 7 → 0x5A in both builds.
- Drive `WE`=1, `WADDR`=2, `WDATA`=0xFF, `RE`=1 during `CLEAR` → `RVALID` stays 0. After `READY`, a read of addr 2 returns 0x00.
- Write 0x3C to addr 5, then assert reset mid-cycle → `RDATA`=0, `RVALID`=0, `READY`=0 immediately. After re-clear, addr 5 reads 0x00. Write to `WADDR`=13 → dropped, and a read of `RADDR`=13 returns 0x00 with `RVALID`=1.
